// File: rtl/bool_sweep_pkg.sv
// rtl/bool_sweep_pkg.sv - shared types and constants for the gate self-test sequencer
package bool_sweep_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRIVE,
        S_WAIT,
        S_SAMPLE,
        S_DONE
    } state_e;

    localparam int IDX_W = 3;
    localparam int CNT_W = 4;

    // Bit i is the expected d = ~((a|b)&c) for {a,b,c} = i
    localparam logic [7:0] EXPECT_DEFAULT = 8'h57;

endpackage

// File: rtl/bool_sweep_ctrl.sv
// rtl/bool_sweep_ctrl.sv - sweeps all {a,b,c} vectors through a gate and scores its output
module bool_sweep_ctrl
    import bool_sweep_pkg::*;
#(
    parameter int         SETTLE_CYCLES = 2,
    parameter logic [7:0] EXPECT        = EXPECT_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             d_in,
    output logic             a_out,
    output logic             b_out,
    output logic             c_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_cnt,
    output logic             err_valid,
    output logic [IDX_W-1:0] first_err_idx
);

    localparam logic [CNT_W-1:0] SETTLE_LAST =
        (SETTLE_CYCLES > 0) ? CNT_W'(SETTLE_CYCLES - 1) : '0;
    localparam logic [IDX_W-1:0] IDX_LAST = '1;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] settle_q, settle_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic             err_valid_q, err_valid_d;
    logic [IDX_W-1:0] first_err_q, first_err_d;
    logic             pass_q, pass_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            settle_q    <= '0;
            err_cnt_q   <= '0;
            err_valid_q <= 1'b0;
            first_err_q <= '0;
            pass_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            settle_q    <= settle_d;
            err_cnt_q   <= err_cnt_d;
            err_valid_q <= err_valid_d;
            first_err_q <= first_err_d;
            pass_q      <= pass_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        settle_d    = settle_q;
        err_cnt_d   = err_cnt_q;
        err_valid_d = err_valid_q;
        first_err_d = first_err_q;
        pass_d      = pass_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d     = S_DRIVE;
                    idx_d       = '0;
                    err_cnt_d   = '0;
                    err_valid_d = 1'b0;
                    first_err_d = '0;
                    pass_d      = 1'b0;
                end
            end
            S_DRIVE: begin
                settle_d = '0;
                state_d  = (SETTLE_CYCLES > 0) ? S_WAIT : S_SAMPLE;
            end
            S_WAIT: begin
                if (settle_q == SETTLE_LAST) begin
                    state_d = S_SAMPLE;
                end else begin
                    settle_d = settle_q + 1'b1;
                end
            end
            S_SAMPLE: begin
                if (d_in != EXPECT[idx_q]) begin
                    err_cnt_d = err_cnt_q + 1'b1;
                    if (!err_valid_q) begin
                        first_err_d = idx_q;
                        err_valid_d = 1'b1;
                    end
                end
                // pass is resolved on entry to DONE so it is valid alongside the done pulse
                if (idx_q == IDX_LAST) begin
                    state_d = S_DONE;
                    pass_d  = (err_cnt_d == '0);
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = S_DRIVE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign a_out         = idx_q[2];
    assign b_out         = idx_q[1];
    assign c_out         = idx_q[0];
    assign busy          = (state_q != S_IDLE);
    assign done          = (state_q == S_DONE);
    assign pass          = pass_q;
    assign err_cnt       = err_cnt_q;
    assign err_valid     = err_valid_q;
    assign first_err_idx = first_err_q;

endmodule

// File: tb/tb_bool_sweep_ctrl.sv
// tb/tb_bool_sweep_ctrl.sv - directed table-driven bench for bool_sweep_ctrl
module tb_bool_sweep_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    logic start;
    int   mode;

    logic       a2, b2, c2, busy2, done2, pass2, valid2, d2;
    logic [3:0] cnt2;
    logic [2:0] first2;
    logic       a0, b0, c0, busy0, done0, pass0, valid0, d0;
    logic [3:0] cnt0;
    logic [2:0] first0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // mode 0: reference gate, 1: stuck at 0, 2: stuck at 1
    assign d2 = (mode == 0) ? ~((a2 | b2) & c2) : (mode == 2);
    assign d0 = ~((a0 | b0) & c0);

    bool_sweep_ctrl #(.SETTLE_CYCLES(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start), .d_in(d2),
        .a_out(a2), .b_out(b2), .c_out(c2), .busy(busy2), .done(done2),
        .pass(pass2), .err_cnt(cnt2), .err_valid(valid2), .first_err_idx(first2)
    );

    bool_sweep_ctrl #(.SETTLE_CYCLES(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .d_in(d0),
        .a_out(a0), .b_out(b0), .c_out(c0), .busy(busy0), .done(done0),
        .pass(pass0), .err_cnt(cnt0), .err_valid(valid0), .first_err_idx(first0)
    );

    typedef struct {
        int         mode;
        int         pa;
        int         pb;
        logic [3:0] exp_cnt;
        logic       exp_pass;
        logic       exp_valid;
        logic [2:0] exp_first;
    } vec_t;

    vec_t vecs[4];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Pulse start, then count cycles after the accepting edge until done
    task automatic sweep(input int pa, input int pb, input bit use0,
                         output int lat, output bit seq_ok);
        logic [2:0] prev;
        logic [2:0] abc;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        lat    = 0;
        seq_ok = 1'b1;
        prev   = 3'd0;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            start = (k == pa) || (k == pb);
            abc   = use0 ? {a0, b0, c0} : {a2, b2, c2};
            if (abc != prev) begin
                if (abc != 3'(prev + 3'd1)) seq_ok = 1'b0;
                prev = abc;
            end
            if (use0 ? done0 : done2) begin
                lat = k;
                break;
            end
        end
        start = 1'b0;
        if (prev != 3'd7) seq_ok = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, int'(busy2), 0);
        chk({tag, "_done"}, int'(done2), 0);
        chk({tag, "_pass"}, int'(pass2), 0);
        chk({tag, "_err_cnt"}, int'(cnt2), 0);
        chk({tag, "_err_valid"}, int'(valid2), 0);
        chk({tag, "_first_err"}, int'(first2), 0);
        chk({tag, "_abc"}, int'({a2, b2, c2}), 0);
    endtask

    initial begin
        int  lat;
        bit  seq_ok;
        bit  saw_done;

        vecs[0] = '{0, 0, 0, 4'd0, 1'b1, 1'b0, 3'd0};
        vecs[1] = '{1, 0, 0, 4'd5, 1'b0, 1'b1, 3'd0};
        vecs[2] = '{2, 0, 0, 4'd3, 1'b0, 1'b1, 3'd3};
        vecs[3] = '{1, 5, 20, 4'd5, 1'b0, 1'b1, 3'd0};

        rst_n = 1'b0;
        start = 1'b0;
        mode  = 0;
        repeat (3) @(negedge clk);
        chk_zero("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int v = 0; v < 4; v++) begin
            mode = vecs[v].mode;
            sweep(vecs[v].pa, vecs[v].pb, 1'b0, lat, seq_ok);
            chk($sformatf("v%0d_latency", v), lat, 33);
            chk($sformatf("v%0d_abc_seq", v), int'(seq_ok), 1);
            chk($sformatf("v%0d_err_cnt", v), int'(cnt2), int'(vecs[v].exp_cnt));
            chk($sformatf("v%0d_pass", v), int'(pass2), int'(vecs[v].exp_pass));
            chk($sformatf("v%0d_err_valid", v), int'(valid2), int'(vecs[v].exp_valid));
            chk($sformatf("v%0d_first_err", v), int'(first2), int'(vecs[v].exp_first));
            @(negedge clk);
            chk($sformatf("v%0d_done_width", v), int'(done2), 0);
            chk($sformatf("v%0d_busy_after", v), int'(busy2), 0);
            chk($sformatf("v%0d_cnt_hold", v), int'(cnt2), int'(vecs[v].exp_cnt));
            chk($sformatf("v%0d_pass_hold", v), int'(pass2), int'(vecs[v].exp_pass));
            repeat (2) @(negedge clk);
        end

        // Reset in the middle of a failing sweep
        mode = 1;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        chk("mid_err_cnt_before", int'(cnt2), 2);
        rst_n = 1'b0;
        #1;
        chk_zero("midreset");
        saw_done = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (done2 || busy2) saw_done = 1'b1;
        end
        chk("midreset_quiet", int'(saw_done), 0);
        rst_n = 1'b1;
        mode  = 0;
        @(negedge clk);
        sweep(0, 0, 1'b0, lat, seq_ok);
        chk("fresh_latency", lat, 33);
        chk("fresh_pass", int'(pass2), 1);
        chk("fresh_err_cnt", int'(cnt2), 0);
        repeat (40) @(negedge clk);

        // Zero settle interval
        sweep(0, 0, 1'b1, lat, seq_ok);
        chk("s0_latency", lat, 17);
        chk("s0_abc_seq", int'(seq_ok), 1);
        chk("s0_pass", int'(pass0), 1);
        chk("s0_err_cnt", int'(cnt0), 0);
        chk("s0_err_valid", int'(valid0), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
